trig_payload_fsm: RTL

Parametrised trigger/payload controller for the instrumented-FSM benchmark family. It sits between a host FSM's combinational outputs and the block outputs. It counts occurrences of a rare (state, input) condition on the host FSM and, once a threshold is reached, applies a configurable corruption (suppress, invert or force) to a masked subset of the host outputs. Compared with fixed hard-coded counters, it adds the following, all set by parameters:
- registered saturating count
- selectable trigger state and input pattern
- three payload modes
- optional self-disarm after a programmable payload duration

---
 rtl/trig_payload_fsm_if.sv | 15 +
 rtl/trig_payload_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/trig_payload_fsm_if.sv
// Host-side bus for trig_payload_fsm: host inputs, state code and outputs, plus the
// (possibly corrupted) outputs returned to the host environment.
interface trig_payload_fsm_if #(
  parameter int IW = 13,
  parameter int OW = 18,
  parameter int SW = 5
);
  logic [IW-1:0] x;
  logic [SW-1:0] host_state;
  logic [OW-1:0] host_y;
  logic [OW-1:0] y;

  modport master (output x, output host_state, output host_y, input y);
  modport slave  (input x, input host_state, input host_y, output y);
endinterface

// File: rtl/trig_payload_fsm.sv
// Trigger/payload controller: counts a rare (state, input) condition on a host FSM and
// corrupts masked host outputs once armed. Optional status ports under `TRIG_STATUS_EN`.
//
// state | meaning
// IDLE  | no qualifying occurrence seen since reset/disarm, cnt = 0
// COUNT | 1..THRESH-1 occurrences accumulated
// ARMED | payload active; persists (PAY_LEN = 0) or self-disarms after PAY_LEN edges
module trig_payload_fsm #(
  parameter int                 IW         = 13,
  parameter int                 OW         = 18,
  parameter int                 SW         = 5,
  parameter int                 CW         = 4,
  parameter int                 THRESH     = 5,
  parameter int                 TRIG_STATE = 9,
  parameter logic [IW-1:0]      TRIG_MASK  = 13'h202,
  parameter logic [IW-1:0]      TRIG_VAL   = 13'h202,
  parameter int                 MODE       = 0,
  parameter logic [OW-1:0]      PAY_MASK   = 18'h3FFFF,
  parameter int                 PAY_LEN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  trig_payload_fsm_if.slave     bus
`ifdef TRIG_STATUS_EN
  ,
  output logic [CW-1:0]         trig_cnt,
  output logic                  armed
`endif
);

  localparam int              DW       = ($clog2(PAY_LEN + 1) < 1) ? 1 : $clog2(PAY_LEN + 1);
  localparam logic [CW-1:0]   THR      = CW'(THRESH);
  localparam logic [CW-1:0]   THR_M1   = CW'(THRESH - 1);
  localparam logic [SW-1:0]   TS       = SW'(TRIG_STATE);
  localparam logic [DW-1:0]   DUR_LAST = DW'((PAY_LEN > 0) ? PAY_LEN - 1 : 0);

  generate
    if (THRESH < 1 || THRESH > (2 ** CW) - 1) begin : g_bad_thresh
      $error("trig_payload_fsm: THRESH out of range for CW");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("trig_payload_fsm: MODE must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ARMED = 2'd2
  } st_t;

  st_t            st, st_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [DW-1:0]  dur, dur_nxt;
  logic           cond;
  logic           fire;
  logic           pay_act;

  assign cond = (bus.host_state == TS) && ((bus.x & TRIG_MASK) == (TRIG_VAL & TRIG_MASK));

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      cnt <= '0;
      dur <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      dur <= dur_nxt;
    end
  end

  // fire marks the occurrence that arms on this edge; it is corrupted combinationally
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    dur_nxt = dur;
    fire    = 1'b0;
    case (st)
      IDLE: begin
        if (cond) begin
          cnt_nxt = CW'(1);
          if (THRESH == 1) begin
            st_nxt  = ARMED;
            dur_nxt = '0;
            fire    = 1'b1;
          end else begin
            st_nxt = COUNT;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      COUNT: begin
        if (cond) begin
          if (cnt == THR_M1) begin
            st_nxt  = ARMED;
            cnt_nxt = THR;
            dur_nxt = '0;
            fire    = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ARMED: begin
        if (PAY_LEN == 0) begin
          cnt_nxt = THR;
        end else if (dur == DUR_LAST) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
          dur_nxt = '0;
        end else begin
          dur_nxt = dur + 1'b1;
        end
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
        dur_nxt = '0;
      end
    endcase
  end

  // reset input gates the payload directly so y is clean while rst is held low
  assign pay_act = rst && ((st == ARMED) || fire);

  always_comb begin
    bus.y = bus.host_y;
    if (pay_act) begin
      case (MODE)
        0:       bus.y = bus.host_y & ~PAY_MASK;
        1:       bus.y = bus.host_y ^ PAY_MASK;
        2:       bus.y = bus.host_y | PAY_MASK;
        default: bus.y = bus.host_y;
      endcase
    end
  end

`ifdef TRIG_STATUS_EN
  assign trig_cnt = cnt;
  assign armed    = (st == ARMED);
`endif

endmodule
